ram_writer: RTL and testbench
=============================

# ram_writer

Write-side companion to the lab RAM reader. It owns a 1024 x 16 RAM and loads bursts of 16-bit words into it through a valid/ready stream, auto-incrementing the address from a programmed base. The stored contents are exposed through the same registered read port (`read`, `am_out`, `ram_out`) the reader uses. It sits between the program/data loader and the instruction-fetch path, so the CPU lab can preload programs such as 0x0304, 0x000a, 0x4304, ... before execution.

## Interface
Parameters:
- `DATA_W`, 16: word width.
- `ADDR_W`, 10: address width; depth is 2^ADDR_W = 1024.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle request to begin a burst; sampled only in IDLE.
- `base_addr`, input, ADDR_W: first write address, captured on an accepted `start`.
- `length`, input, ADDR_W+1: words in the burst, captured on an accepted `start`; 0 is legal; values above 1024 are clamped to 1024.
- `data_valid`, input, 1: producer has a word on `data_in`.
- `data_in`, input, DATA_W: write data.
- `data_ready`, output, 1: block accepts a word this cycle.
- `busy`, output, 1: high in LOAD and DONE.
- `done`, output, 1: one-cycle pulse when a burst completes.
- `wr_count`, output, ADDR_W+1: words written in the current or last burst.
- `read`, input, 1: read enable.
- `am_out`, input, ADDR_W: read address.
- `ram_out`, output, DATA_W: registered read data.

## Operation
The control FSM has three states: IDLE, LOAD, DONE.
- **IDLE**
  - `start`=1 with clamped length != 0: capture `base_addr` into `wr_addr`, capture the length, clear `wr_count`, go to LOAD.
  - `start`=1 with length == 0: clear `wr_count`, go to DONE. No RAM write occurs.
- **LOAD**
  - `data_ready`=1.
  - A transfer happens on any rising edge where `data_valid` && `data_ready`. On a transfer: `mem[wr_addr]` <= `data_in`; `wr_addr` <= `wr_addr` + 1 modulo 1024 (0x3FF wraps to 0x000); `wr_count` += 1.
  - The transfer that makes `wr_count` equal the length moves the FSM to DONE.
  - `data_valid`=0 stalls with no side effects. There is no timeout.
- **DONE**: `done`=1 and `data_ready`=0 for exactly one cycle, then go to IDLE.
- `start` in LOAD or DONE is ignored and has no effect on the captured registers.
- `wr_count` holds its final value in IDLE until the next accepted `start`.
- A 1024-word burst fills the whole RAM once. With a nonzero base it wraps and overwrites nothing twice.
- Read port: on a rising edge with `read`=1, `ram_out` <= `mem[am_out]`. With `read`=0, `ram_out` holds its value. The read port is independent of the FSM and is usable in any state.
- Same-address read and write on the same edge: `ram_out` returns the old contents (read-before-write).
- RAM contents are not reset and are not altered by `rst`.

## Timing
- Reset values (asynchronous, on `rst`=0): FSM in IDLE; `data_ready`=0, `busy`=0, `done`=0, `wr_count`=0, `ram_out`=0x0000; `wr_addr` and the captured length are cleared to 0.
- Reset asserted mid-burst: the burst is aborted immediately and the block stays in IDLE after release. Words already written remain in the RAM.
- `start` accepted at edge N:
  - `busy` and `data_ready` are high after edge N.
  - The first write can occur at edge N+1.
- Throughput is 1 word/cycle with `data_valid` held high. An L-word burst started at edge N has its last write at edge N+L.
- `done` is high in the cycle after edge N+L; `busy` drops after edge N+L+1. For length 0, `done` is high in the cycle after edge N.
- Read latency is 1 cycle: the address is presented and `read`=1 before edge M, and data is valid after edge M.
- Outputs are registered or decoded from state only. `data_ready` is not combinationally dependent on `data_valid`.

## Test plan
- **Program load:** reset, `start` with base 0, length 10, then stream 0x0304, 0x000a, 0x4304, 0x0000, 0xe304, 0x0000, 0xc304, 0x0000, 0xe110, 0x0016 with `data_valid` held high. Required: `done` pulses 11 cycles after `start`; `wr_count`=10; reading addresses 0..9 returns the same ten words.
- **Backpressure:** base 0x020, length 4, `data_valid` toggling 1,0,0,1,1,0,1. Required: exactly 4 writes, 0x020..0x023 hold the 4 valid words, and nothing is written on idle cycles.
- **Wrap-around:** base 0x3FE, length 4, data 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD. Required: 0x3FE=0xAAAA, 0x3FF=0xBBBB, 0x000=0xCCCC, 0x001=0xDDDD.
- **Length edge cases:**
  - Length 0: `done` one cycle after `start`, no RAM change, `wr_count`=0.
  - Length 2047: clamped; exactly 1024 words accepted.
- **Start while busy and read collision:** a second `start` mid-burst is ignored, with base and length unchanged. A read and write of the same address on one edge returns the prior value; the next read returns the new value.
- **Reset mid-burst:** assert `rst`=0 after 3 of 8 words. Required: all outputs go to their reset values immediately; 3 words remain in the RAM; `data_ready` stays 0 until the next `start`.

Source files
------------

// File: rtl/ram_writer_if.sv
// Stream, control and read-port bundle for ram_writer.
// master drives requests and data; slave is the writer.
interface ram_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              data_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic              read;
  logic [ADDR_W-1:0] am_out;
  logic [DATA_W-1:0] ram_out;

  modport master (
    output start, base_addr, length,
    output data_valid, data_in,
    output read, am_out,
    input  data_ready, busy, done,
    input  wr_count, ram_out
  );

  modport slave (
    input  start, base_addr, length,
    input  data_valid, data_in,
    input  read, am_out,
    output data_ready, busy, done,
    output wr_count, ram_out
  );
endinterface

// File: rtl/ram_writer.sv
// Burst loader for a 1024x16 RAM with auto-increment address.
// Registered read port shared with the instruction-fetch side.
module ram_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  ram_writer_if.slave s
);
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE =
    (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len_cl;
  logic [ADDR_W:0]   cnt_nx;
  logic              rdy;
  logic              bsy;
  logic              dn;
  logic              we;
  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign len_cl = (s.length > MAX_LEN) ?
                  MAX_LEN : s.length;
  assign cnt_nx = cnt + ONE;
  assign we     = rdy & s.data_valid;

  assign s.data_ready = rdy;
  assign s.busy       = bsy;
  assign s.done       = dn;
  assign s.wr_count   = cnt;
  assign s.ram_out    = rd;

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wr_addr <= '0;
      len     <= '0;
      cnt     <= '0;
      rdy     <= 1'b0;
      bsy     <= 1'b0;
      dn      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s.start) begin
            cnt <= '0;
            bsy <= 1'b1;
            if (len_cl != '0) begin
              wr_addr <= s.base_addr;
              len     <= len_cl;
              rdy     <= 1'b1;
              state   <= LOAD;
            end else begin
              dn    <= 1'b1;
              state <= DONE;
            end
          end
        end
        LOAD: begin
          if (we) begin
            wr_addr <= wr_addr + 1'b1;
            cnt     <= cnt_nx;
            if (cnt_nx == len) begin
              rdy   <= 1'b0;
              dn    <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          dn    <= 1'b0;
          bsy   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rdy   <= 1'b0;
          bsy   <= 1'b0;
          dn    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= s.data_in;
  end

  // Registered read, old data on same-edge collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd <= '0;
    else if (s.read) rd <= mem[s.am_out];
  end
endmodule

// File: tb/tb_ram_writer.sv
// Directed bench for ram_writer with a
// transaction-level reference model.
module tb_ram_writer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   t_done = -1;
  int   t_start = 0;
  int   xfers = 0;

  ram_writer_if #(.DATA_W(16), .ADDR_W(10)) s ();

  ram_writer #(.DATA_W(16), .ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_mem [1024];
  bit          m_known [1024];
  bit          m_loading, m_done, m_rd_ok;
  int          m_rem, m_addr, m_count;
  logic [15:0] m_rd;

  function automatic int clampf(input int l);
    return (l > 1024) ? 1024 : l;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_loading <= 0;
      m_done    <= 0;
      m_rem     <= 0;
      m_addr    <= 0;
      m_count   <= 0;
      m_rd      <= 16'h0000;
      m_rd_ok   <= 1;
    end else begin
      if (s.read) begin
        m_rd    <= m_mem[s.am_out];
        m_rd_ok <= m_known[s.am_out];
      end
      if (m_done) begin
        m_done <= 0;
      end else if (m_loading) begin
        if (s.data_valid) begin
          m_mem[m_addr]   <= s.data_in;
          m_known[m_addr] <= 1;
          m_addr  <= (m_addr + 1) % 1024;
          m_count <= m_count + 1;
          m_rem   <= m_rem - 1;
          if (m_rem == 1) begin
            m_loading <= 0;
            m_done    <= 1;
          end
        end
      end else if (s.start) begin
        m_count <= 0;
        if (clampf(int'(s.length)) == 0) begin
          m_done <= 1;
        end else begin
          m_loading <= 1;
          m_rem     <= clampf(int'(s.length));
          m_addr    <= int'(s.base_addr);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("data_ready", s.data_ready, m_loading);
    chk("busy", s.busy, m_loading | m_done);
    chk("done", s.done, m_done);
    chk("wr_count", s.wr_count, m_count);
    if (m_rd_ok) chk("ram_out", s.ram_out, m_rd);
  end

  // ---------------- monitors ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst && s.data_valid && s.data_ready)
      xfers++;
  end

  always @(posedge clk) begin
    #1;
    if (s.done === 1'b1) begin
      done_cnt++;
      t_done = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [9:0] b,
                          input logic [10:0] l);
    @(negedge clk);
    s.start = 1'b1;
    s.base_addr = b;
    s.length = l;
    @(posedge clk);
    #1 t_start = cyc;
    @(negedge clk);
    s.start = 1'b0;
  endtask

  task automatic push(input logic [15:0] d,
                      input bit v);
    s.data_valid = v;
    s.data_in = d;
    @(negedge clk);
    s.data_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt != prev, 1);
  endtask

  task automatic rd(input logic [9:0] a,
                    input logic [15:0] exp,
                    input string nm);
    @(negedge clk);
    s.read = 1'b1;
    s.am_out = a;
    @(negedge clk);
    s.read = 1'b0;
    chk(nm, s.ram_out, exp);
  endtask

  logic [15:0] prog [10] = '{
    16'h0304, 16'h000a, 16'h4304, 16'h0000,
    16'he304, 16'h0000, 16'hc304, 16'h0000,
    16'he110, 16'h0016
  };
  bit          bp_v [7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [15:0] bp_d [7] = '{
    16'h1111, 16'hdead, 16'hdead, 16'h2222,
    16'h3333, 16'hdead, 16'h4444
  };
  logic [15:0] wr_d [4] = '{
    16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd
  };

  initial begin
    int prev, x0;
    s.start = 0; s.base_addr = 0; s.length = 0;
    s.data_valid = 0; s.data_in = 0;
    s.read = 0; s.am_out = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", s.data_ready, 0);
    chk("rst_busy", s.busy, 0);
    chk("rst_done", s.done, 0);
    chk("rst_count", s.wr_count, 0);
    chk("rst_ram_out", s.ram_out, 0);
    rst = 1'b1;
    @(negedge clk);

    // Program load
    prev = done_cnt;
    do_start(10'h000, 11'd10);
    for (int i = 0; i < 10; i++) push(prog[i], 1);
    wait_done(prev);
    chk("prog_done_lat", t_done - t_start, 10);
    chk("prog_count", s.wr_count, 10);
    for (int i = 0; i < 10; i++)
      rd(10'(i), prog[i], "prog_read");

    // Backpressure
    x0 = xfers;
    prev = done_cnt;
    do_start(10'h020, 11'd4);
    for (int i = 0; i < 7; i++) push(bp_d[i], bp_v[i]);
    wait_done(prev);
    chk("bp_xfers", xfers - x0, 4);
    rd(10'h020, 16'h1111, "bp_20");
    rd(10'h021, 16'h2222, "bp_21");
    rd(10'h022, 16'h3333, "bp_22");
    rd(10'h023, 16'h4444, "bp_23");

    // Wrap-around
    prev = done_cnt;
    do_start(10'h3fe, 11'd4);
    for (int i = 0; i < 4; i++) push(wr_d[i], 1);
    wait_done(prev);
    rd(10'h3fe, 16'haaaa, "wrap_3fe");
    rd(10'h3ff, 16'hbbbb, "wrap_3ff");
    rd(10'h000, 16'hcccc, "wrap_000");
    rd(10'h001, 16'hdddd, "wrap_001");

    // Length 0
    x0 = xfers;
    prev = done_cnt;
    do_start(10'h000, 11'd0);
    wait_done(prev);
    chk("len0_lat", t_done - t_start, 0);
    chk("len0_count", s.wr_count, 0);
    chk("len0_xfers", xfers - x0, 0);
    rd(10'h000, 16'hcccc, "len0_ram");

    // Length 2047 clamps to a full-RAM pass
    x0 = xfers;
    prev = done_cnt;
    do_start(10'h100, 11'd2047);
    for (int i = 0; i < 1028; i++)
      push(16'(i) ^ 16'h5a5a, 1);
    wait_done(prev);
    chk("clamp_xfers", xfers - x0, 1024);
    chk("clamp_count", s.wr_count, 1024);
    rd(10'h100, 16'h5a5a, "clamp_first");
    rd(10'h0ff, 16'h59a5, "clamp_last");

    // Start while busy, plus read/write collision
    prev = done_cnt;
    do_start(10'h050, 11'd4);
    push(16'h0a01, 1);
    push(16'h0a02, 1);
    s.start = 1; s.base_addr = 10'h300;
    s.length = 11'd1;
    s.read = 1; s.am_out = 10'h052;
    s.data_valid = 1; s.data_in = 16'h0a03;
    @(negedge clk);
    s.start = 0;
    chk("coll_old", s.ram_out, 16'h5908);
    s.data_in = 16'h0a04;
    @(negedge clk);
    s.read = 0; s.data_valid = 0;
    chk("coll_new", s.ram_out, 16'h0a03);
    wait_done(prev);
    chk("busy_start_count", s.wr_count, 4);
    rd(10'h053, 16'h0a04, "busy_start_53");
    rd(10'h300, 16'h585a, "busy_start_300");

    // Reset mid-burst
    x0 = xfers;
    do_start(10'h200, 11'd8);
    for (int i = 0; i < 3; i++) push(16'hb000 + 16'(i), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", s.data_ready, 0);
    chk("mid_rst_busy", s.busy, 0);
    chk("mid_rst_done", s.done, 0);
    chk("mid_rst_count", s.wr_count, 0);
    chk("mid_rst_ram_out", s.ram_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    s.data_valid = 1; s.data_in = 16'hffff;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", s.data_ready, 0);
    s.data_valid = 0;
    chk("mid_rst_xfers", xfers - x0, 3);
    rd(10'h200, 16'hb000, "mid_rst_200");
    rd(10'h201, 16'hb001, "mid_rst_201");
    rd(10'h202, 16'hb002, "mid_rst_202");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
